// File: rtl/router_input_port.sv
`default_nettype none
// ============================================================================
//  Module   : router_input_port
//  Purpose  : Input port of a 4x4 mesh router on the link from a processing
//             element. Buffers incoming flits in a DEPTH-entry FIFO, exposes
//             the head flit show-ahead, computes an XY dimension-order route
//             request for it, and returns one credit pulse per drained flit.
//  Ports    : clk        - clock, rising edge
//             RST        - asynchronous active-low reset
//             in_data    - flit from upstream PE
//             in_valid   - in_data valid (credit controlled, no ready)
//             credit_out - one-cycle pulse per flit popped (to PE ci)
//             out_data   - head flit (show-ahead)
//             out_valid  - FIFO non-empty
//             out_ready  - switch allocator accepts head flit
//             out_port   - route for head: 0=LOCAL 1=NORTH 2=SOUTH 3=EAST 4=WEST
//             overflow   - sticky: write attempted while full without a pop
//             occupancy  - entries currently held (0..DEPTH)
//  Flit     : [19:18] dest X, [17:16] dest Y, [15:14] src X, [13:12] src Y,
//             [11:0] payload
//  Revision : 1.0 - initial release
// ============================================================================
module router_input_port #(
    parameter int DATA_W = 20,
    parameter int DEPTH  = 4,
    parameter int MY_X   = 1,
    parameter int MY_Y   = 1
) (
    input  logic              clk,
    input  logic              RST,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              credit_out,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        out_port,
    output logic              overflow,
    output logic [2:0]        occupancy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
    localparam logic [2:0]       OCC_FULL  = 3'(DEPTH);

    localparam logic [1:0] MY_X_C = 2'(MY_X);
    localparam logic [1:0] MY_Y_C = 2'(MY_Y);

    localparam logic [2:0] PORT_LOCAL = 3'd0;
    localparam logic [2:0] PORT_NORTH = 3'd1;
    localparam logic [2:0] PORT_SOUTH = 3'd2;
    localparam logic [2:0] PORT_EAST  = 3'd3;
    localparam logic [2:0] PORT_WEST  = 3'd4;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]        occ_q, occ_d;
    logic              valid_q, valid_d;
    logic              credit_q, credit_d;
    logic              overflow_q, overflow_d;

    logic              full;
    logic              pop;
    logic              push;

    logic [1:0]        dst_x;
    logic [1:0]        dst_y;
    logic [2:0]        route_port;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    assign full = (occ_q == OCC_FULL);
    // out_ready is only meaningful while a head flit is presented.
    assign pop  = valid_q && out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still
    // accept a write when it is draining simultaneously.
    assign push = in_valid && (!full || pop);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;
        overflow_d = overflow_q;

        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   occ_d = occ_q + 3'd1;
            2'b01:   occ_d = occ_q - 3'd1;
            default: occ_d = occ_q;
        endcase

        // Dropped write: sticky until reset, storage left untouched.
        if (in_valid && !push) begin
            overflow_d = 1'b1;
        end

        valid_d  = (occ_d != 3'd0);
        credit_d = pop;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= 3'd0;
            valid_q    <= 1'b0;
            credit_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            valid_q    <= valid_d;
            credit_q   <= credit_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is cleared on reset so the show-ahead output reads zero
    // immediately after reset.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    // ------------------------------------------------------------------
    // Route compute: X first, then Y, from the presented head flit
    // ------------------------------------------------------------------
    assign dst_x = out_data[DATA_W-1 -: 2];
    assign dst_y = out_data[DATA_W-3 -: 2];

    always_comb begin
        route_port = PORT_LOCAL;
        if (valid_q) begin
            if (dst_x > MY_X_C) begin
                route_port = PORT_EAST;
            end else if (dst_x < MY_X_C) begin
                route_port = PORT_WEST;
            end else if (dst_y > MY_Y_C) begin
                route_port = PORT_SOUTH;
            end else if (dst_y < MY_Y_C) begin
                route_port = PORT_NORTH;
            end else begin
                route_port = PORT_LOCAL;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign out_data   = mem_q[rd_ptr_q];
    assign out_valid  = valid_q;
    assign out_port   = route_port;
    assign credit_out = credit_q;
    assign overflow   = overflow_q;
    assign occupancy  = occ_q;

endmodule
`default_nettype wire
